// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  localparam int START_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle of requester handshakes and transmitter launch signals around the scheduler.
interface uart_tx_scheduler_if;

  logic       req0_valid;
  logic       req1_valid;
  logic [7:0] req0_data;
  logic [7:0] req1_data;
  logic       req0_ready;
  logic       req1_ready;
  logic       tx_data_valid;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       grant_id;
  logic       active;
  logic       timeout_err;

  // master: the scheduler side; slave: requesters plus transmitter
  modport master (
    input  req0_valid, req1_valid, req0_data, req1_data, tx_busy,
    output req0_ready, req1_ready, tx_data_valid, tx_data, grant_id, active, timeout_err
  );

  modport slave (
    output req0_valid, req1_valid, req0_data, req1_data, tx_busy,
    input  req0_ready, req1_ready, tx_data_valid, tx_data, grant_id, active, timeout_err
  );

endinterface

// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin scheduler feeding one byte at a time to a UART transmitter,
// abandoning a launch the transmitter never picks up.
module uart_tx_scheduler
  import uart_pkg::*;
#(
    parameter int START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       tx_data_valid,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       grant_id,
    output logic       active,
    output logic       timeout_err
);

    localparam int CW = $clog2(START_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(START_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          busy_q;
    logic          take;
    logic          grant_sel;
    logic          timeout_hit;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        grant_sel   = 1'b0;
        take        = 1'b0;
        timeout_hit = 1'b0;

        // A tie goes to whichever requester was not served last.
        grant_sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

        // Grants wait for the transmitter to have been idle for a full cycle; rst_n
        // keeps the combinational strobes quiet while reset is held.
        take = rst_n && (state == IDLE) && (req0_valid || req1_valid) && !tx_busy && !busy_q;

        unique case (state)
            IDLE:       if (take) state_nxt = ISSUE;
            ISSUE:      state_nxt = WAIT_START;
            WAIT_START: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WAIT_DONE:  if (!tx_busy) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    assign req0_ready    = take && !grant_sel;
    assign req1_ready    = take &&  grant_sel;
    assign tx_data_valid = (state == ISSUE);
    assign active        = (state != IDLE);

    // NOTE: state elements use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_data     <= 8'h00;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            cnt         <= '0;
            busy_q      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy_q      <= tx_busy;
            timeout_err <= timeout_hit;

            if (take) begin
                tx_data  <= grant_sel ? req1_data : req0_data;
                grant_id <= grant_sel;
            end

            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT_START && !tx_busy && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            // A timed-out requester still counts as served, so the other one gets priority.
            if (timeout_hit || (state == WAIT_DONE && !tx_busy)) begin
                last_grant <= grant_id;
            end
        end
    end

endmodule
